// File: rtl/minv_io_ctrl.sv
// Word-serial operand loader and result unloader around the modular inverse core.
// Loads x/y/p word by word into the core bank, launches the core, then streams the result out.
module minv_io_ctrl #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_sel,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      start,
    output logic                      load_we,
    output logic [1:0]                load_sel,
    output logic [$clog2(NWORDS)-1:0] load_idx,
    output logic [WORD_W-1:0]         load_data,
    output logic                      minv_en,
    input  logic                      minv_rdy,
    output logic [$clog2(NWORDS)-1:0] res_rd_idx,
    input  logic [WORD_W-1:0]         res_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // state | meaning
    // IDLE  | accept operand words, wait for start
    // ARM   | single-cycle core launch (minv_en)
    // RUN   | core computing, wait for minv_rdy
    // DRAIN | stream result words out
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int IDX_W = $clog2(NWORDS);
    localparam int CNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt [3];
    logic [IDX_W-1:0] ridx;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_ok;
    logic             all_full;
    logic             accept;

    // Illegal target reads as full so it can never be accepted
    always_comb begin
        sel_cnt = CNT_FULL;
        case (in_sel)
            2'd0:    sel_cnt = cnt[0];
            2'd1:    sel_cnt = cnt[1];
            2'd2:    sel_cnt = cnt[2];
            default: sel_cnt = CNT_FULL;
        endcase
    end

    assign sel_ok     = (in_sel != 2'd3) && (sel_cnt < CNT_FULL);
    assign in_ready   = (state == S_IDLE) && sel_ok;
    assign accept     = in_valid && in_ready;
    assign all_full   = (cnt[0] == CNT_FULL) && (cnt[1] == CNT_FULL) && (cnt[2] == CNT_FULL);

    assign minv_en    = (state == S_ARM);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DRAIN);
    assign res_rd_idx = (state == S_DRAIN) ? ridx : '0;
    assign out_data   = res_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            ridx      <= '0;
            load_we   <= 1'b0;
            load_sel  <= '0;
            load_idx  <= '0;
            load_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int t = 0; t < 3; t++) cnt[t] <= '0;
        end else if (clr) begin
            state   <= S_IDLE;
            ridx    <= '0;
            load_we <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int t = 0; t < 3; t++) cnt[t] <= '0;
        end else begin
            load_we <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        load_we   <= 1'b1;
                        load_sel  <= in_sel;
                        load_idx  <= sel_cnt[IDX_W-1:0];
                        load_data <= in_data;
                        for (int t = 0; t < 3; t++)
                            if (in_sel == 2'(t)) cnt[t] <= cnt[t] + CNT_ONE;
                    end
                    // all_full uses pre-handshake counts, so a start alongside the last word errors
                    if (start) begin
                        if (all_full) state <= S_ARM;
                        else          err   <= 1'b1;
                    end
                end
                S_ARM: state <= S_RUN;
                S_RUN: begin
                    if (minv_rdy) begin
                        state <= S_DRAIN;
                        ridx  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (ridx == IDX_LAST) begin
                            state <= S_IDLE;
                            ridx  <= '0;
                            done  <= 1'b1;
                            for (int t = 0; t < 3; t++) cnt[t] <= '0;
                        end else begin
                            ridx <= ridx + IDX_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
